mem_responder: RTL

Word-organised on-chip memory acting as the responder end of the core's data/instruction memory port. Accepts one request at a time (address, RISC-V funct3 size code, write data, write enable) and returns load data aligned, sign- or zero-extended to 32 bits. Byte-lane stores go directly to the array. Sits between the multi-cycle core and its backing store; it also supplies the boot PC on the read-data bus during reset.

---
 rtl/mem_responder_if.sv | 28 ++
 rtl/mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_responder_if                                                          |
// | Request/response bundle between the core and its on-chip memory.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_responder                                                             |
// | Word-organised memory responder: byte/half/word loads and stores with    |
// | sign/zero extension. MEM_MISALIGN_EN enables word-crossing accesses.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BOOT_PC     = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef MEM_MISALIGN_EN
    S_SPLIT = 2'd1,
`endif
    S_RESP  = 2'd2
  } state_t;

  // Request decode
  logic          w_accept;
  logic [2:0]    w_nbytes;
  logic [3:0]    w_nmask;
  logic          w_size_bad;
  logic          w_store_bad;
  logic          w_oob;
  logic          w_cross;
  logic          w_err;
  logic [1:0]    w_off;
  logic [AW-1:0] w_idx;

  always_comb begin
    w_nbytes   = 3'd4;
    w_nmask    = 4'b1111;
    w_size_bad = 1'b0;
    case (bus.req_size)
      3'd0, 3'd4: begin w_nbytes = 3'd1; w_nmask = 4'b0001; end
      3'd1, 3'd5: begin w_nbytes = 3'd2; w_nmask = 4'b0011; end
      3'd2:       begin w_nbytes = 3'd4; w_nmask = 4'b1111; end
      default:    w_size_bad = 1'b1;
    endcase
  end

  assign w_accept    = bus.req_valid & bus.req_ready;
  assign w_off       = bus.req_addr[1:0];
  assign w_idx       = bus.req_addr[AW+1:2];
  assign w_oob       = (bus.req_addr >> (AW + 2)) != 32'd0;
  assign w_cross     = ({2'b00, w_off} + {1'b0, w_nbytes}) > 4'd4;
  assign w_store_bad = bus.req_we & bus.req_size[2];

`ifdef MEM_MISALIGN_EN
  // No wrap-around: a crossing access from the last word has nowhere to go.
  assign w_err = w_size_bad | w_store_bad | w_oob | (w_cross & (&w_idx));

  logic [7:0]  w_be8;
  logic [63:0] w_wdata64;
  assign w_be8     = {4'b0000, w_nmask} << w_off;
  assign w_wdata64 = {32'd0, bus.req_wdata} << {w_off, 3'b000};
`else
  assign w_err = w_size_bad | w_store_bad | w_oob | w_cross;

  logic [3:0]  w_be4;
  logic [31:0] w_wdata32;
  assign w_be4     = w_nmask << w_off;
  assign w_wdata32 = bus.req_wdata << {w_off, 3'b000};
`endif

  // Control/state registers
  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;
  logic        err_hold_q, err_hold_d;
`ifdef MEM_MISALIGN_EN
  logic [AW-1:0] idx_hi_q, idx_hi_d;
  logic [31:0]   wdata_hi_q, wdata_hi_d;
  logic [3:0]    be_hi_q, be_hi_d;
  logic          w_rd_hi;
`endif

  // Single shared array port
  logic          w_wr_en;
  logic [AW-1:0] w_wr_idx;
  logic [3:0]    w_wr_be;
  logic [31:0]   w_wr_data;
  logic          w_rd_lo;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_fmt;

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    we_d         = we_q;
    err_d        = err_q;
    rdata_hold_d = rdata_hold_q;
    err_hold_d   = err_hold_q;
    w_wr_en      = 1'b0;
    w_wr_idx     = w_idx;
    w_rd_lo      = 1'b0;
    w_rd_idx     = w_idx;
`ifdef MEM_MISALIGN_EN
    idx_hi_d     = idx_hi_q;
    wdata_hi_d   = wdata_hi_q;
    be_hi_d      = be_hi_q;
    w_rd_hi      = 1'b0;
    w_wr_be      = w_be8[3:0];
    w_wr_data    = w_wdata64[31:0];
`else
    w_wr_be      = w_be4;
    w_wr_data    = w_wdata32;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          off_d   = w_off;
          size_d  = bus.req_size;
          we_d    = bus.req_we;
          err_d   = w_err;
          w_wr_en = bus.req_we & ~w_err;
          w_rd_lo = ~bus.req_we & ~w_err;
`ifdef MEM_MISALIGN_EN
          idx_hi_d   = w_idx + AW'(1);
          wdata_hi_d = w_wdata64[63:32];
          be_hi_d    = w_be8[7:4];
          state_d    = (w_cross & ~w_err) ? S_SPLIT : S_RESP;
`else
          state_d    = S_RESP;
`endif
        end
      end
`ifdef MEM_MISALIGN_EN
      S_SPLIT: begin
        w_wr_en   = we_q;
        w_wr_idx  = idx_hi_q;
        w_wr_be   = be_hi_q;
        w_wr_data = wdata_hi_q;
        w_rd_hi   = ~we_q;
        w_rd_idx  = idx_hi_q;
        state_d   = S_RESP;
      end
`endif
      S_RESP: begin
        rdata_hold_d = w_fmt;
        err_hold_d   = err_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      off_q        <= 2'd0;
      size_q       <= 3'd0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      rdata_hold_q <= BOOT_PC;
      err_hold_q   <= 1'b0;
`ifdef MEM_MISALIGN_EN
      idx_hi_q     <= '0;
      wdata_hi_q   <= 32'd0;
      be_hi_q      <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      we_q         <= we_d;
      err_q        <= err_d;
      rdata_hold_q <= rdata_hold_d;
      err_hold_q   <= err_hold_d;
`ifdef MEM_MISALIGN_EN
      idx_hi_q     <= idx_hi_d;
      wdata_hi_q   <= wdata_hi_d;
      be_hi_q      <= be_hi_d;
`endif
    end
  end

  // Array: contents survive reset; a reset in SPLIT suppresses the beat-2 write.
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_lo_q;
`ifdef MEM_MISALIGN_EN
  logic [31:0] rd_hi_q;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (w_wr_be[k]) mem[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
      end
    end
    if (w_rd_lo) rd_lo_q <= mem[w_rd_idx];
`ifdef MEM_MISALIGN_EN
    if (w_rd_hi) rd_hi_q <= mem[w_rd_idx];
`endif
  end

  // Load alignment and extension
  logic [31:0] w_win;
`ifdef MEM_MISALIGN_EN
  assign w_win = 32'({rd_hi_q, rd_lo_q} >> {off_q, 3'b000});
`else
  assign w_win = rd_lo_q >> {off_q, 3'b000};
`endif

  always_comb begin
    w_fmt = 32'd0;
    if (!we_q && !err_q) begin
      case (size_q)
        3'd0:    w_fmt = {{24{w_win[7]}}, w_win[7:0]};
        3'd1:    w_fmt = {{16{w_win[15]}}, w_win[15:0]};
        3'd2:    w_fmt = w_win;
        3'd4:    w_fmt = {24'd0, w_win[7:0]};
        3'd5:    w_fmt = {16'd0, w_win[15:0]};
        default: w_fmt = 32'd0;
      endcase
    end
  end

  assign bus.req_ready = ~rst & (state_q == S_IDLE);
  assign bus.rsp_valid = ~rst & (state_q == S_RESP);
  assign bus.rsp_err   = ~rst & ((state_q == S_RESP) ? err_q : err_hold_q);
  assign bus.rsp_rdata = rst ? BOOT_PC
                             : ((state_q == S_RESP) ? w_fmt : rdata_hold_q);
endmodule
`default_nettype wire
